// File: rtl/beat_sequencer.sv
// Beat-position sequencer for the music player: tempo divider, play/pause,
// clamped hold-loop and wrap-capable A-B loop driving the decoder's ibeat index.
module beat_sequencer #(
    parameter int LEN      = 64,
    parameter int BEAT_W   = 12,
    parameter int BASE_DIV = 12500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play_1p,
    input  logic              speedup_1p,
    input  logic              speeddown_1p,
    input  logic              loop_hold,
    input  logic [2:0]        loop_width,
    input  logic              ab_mark_1p,
    output logic [BEAT_W-1:0] ibeat,
    output logic              playing,
    output logic [2:0]        speed,
    output logic              beat_tick,
    output logic [1:0]        ab_state
);

    typedef enum logic [1:0] {
        AB_IDLE   = 2'd0,
        AB_A_SET  = 2'd1,
        AB_ACTIVE = 2'd2
    } ab_state_e;

    localparam logic [31:0]       BASE_PERIOD = 32'(BASE_DIV * 4);
    localparam logic [31:0]       LEN_W       = 32'(LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(LEN - 1);
    localparam logic [2:0]        SPEED_MAX   = 3'd4;
    localparam logic [2:0]        SPEED_RST   = 3'd2;

    logic [BEAT_W-1:0] ibeat_q, ibeat_d;
    logic [BEAT_W-1:0] a_q, a_d, b_q, b_d;
    logic [BEAT_W-1:0] h_start_q, h_start_d, h_end_q, h_end_d;
    logic              playing_q, playing_d;
    logic              beat_tick_q, beat_tick_d;
    logic              hold_q, hold_d;
    logic [2:0]        speed_q, speed_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       period_q, period_d;
    ab_state_e         ab_q, ab_d;

    logic              speed_up, speed_dn, speed_chg, advance, hold_rise;
    logic [2:0]        width;
    logic [31:0]       h_lin;
    logic [BEAT_W-1:0] next_beat;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch can be inferred.
        speed_up  = speedup_1p && !speeddown_1p && (speed_q != SPEED_MAX);
        speed_dn  = speeddown_1p && !speedup_1p && (speed_q != 3'd0);
        speed_chg = speed_up || speed_dn;

        // A pause pulse or a tempo change in the same cycle suppresses the advance.
        advance = playing_q && !play_1p && !speed_chg && (cnt_q == period_q - 32'd1);

        if (hold_q && (ibeat_q == h_end_q)) begin
            next_beat = h_start_q;
        end else if ((ab_q == AB_ACTIVE) && (ibeat_q == b_q)) begin
            next_beat = a_q;
        end else if (ibeat_q == LAST_BEAT) begin
            next_beat = '0;
        end else begin
            next_beat = ibeat_q + BEAT_W'(1);
        end

        width = loop_width;
        if (loop_width < 3'd2) begin
            width = 3'd2;
        end else if (loop_width > 3'd6) begin
            width = 3'd6;
        end
        // Single wrap subtraction is enough because LEN is at least the widest loop.
        h_lin     = 32'(ibeat_q) + 32'(width) - 32'd1;
        hold_rise = loop_hold && !hold_q;

        playing_d = playing_q ^ play_1p;

        speed_d = speed_q;
        if (speed_up) begin
            speed_d = speed_q + 3'd1;
        end else if (speed_dn) begin
            speed_d = speed_q - 3'd1;
        end
        period_d = BASE_PERIOD >> speed_d;

        cnt_d = cnt_q;
        if (speed_chg || advance) begin
            cnt_d = '0;
        end else if (playing_q && !play_1p) begin
            cnt_d = cnt_q + 32'd1;
        end

        ibeat_d     = advance ? next_beat : ibeat_q;
        beat_tick_d = advance;

        hold_d    = loop_hold;
        h_start_d = h_start_q;
        h_end_d   = h_end_q;
        if (hold_rise) begin
            h_start_d = ibeat_q;
            h_end_d   = BEAT_W'((h_lin >= LEN_W) ? h_lin - LEN_W : h_lin);
        end

        ab_d = ab_q;
        a_d  = a_q;
        b_d  = b_q;
        if (ab_mark_1p) begin
            case (ab_q)
                AB_IDLE: begin
                    a_d  = ibeat_q;
                    ab_d = AB_A_SET;
                end
                AB_A_SET: begin
                    if (ibeat_q == a_q) begin
                        ab_d = AB_IDLE;
                    end else begin
                        b_d  = ibeat_q;
                        ab_d = AB_ACTIVE;
                    end
                end
                default: ab_d = AB_IDLE;
            endcase
        end
    end

    // NOTE: state is updated only with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ibeat_q     <= '0;
            playing_q   <= 1'b0;
            speed_q     <= SPEED_RST;
            period_q    <= BASE_PERIOD >> SPEED_RST;
            beat_tick_q <= 1'b0;
            ab_q        <= AB_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            h_start_q   <= '0;
            h_end_q     <= '0;
            hold_q      <= 1'b0;
        end else begin
            ibeat_q     <= ibeat_d;
            playing_q   <= playing_d;
            speed_q     <= speed_d;
            period_q    <= period_d;
            beat_tick_q <= beat_tick_d;
            ab_q        <= ab_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            h_start_q   <= h_start_d;
            h_end_q     <= h_end_d;
            hold_q      <= hold_d;
        end
    end

    assign ibeat     = ibeat_q;
    assign playing   = playing_q;
    assign speed     = speed_q;
    assign beat_tick = beat_tick_q;
    assign ab_state  = ab_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Scoreboard bench for beat_sequencer (LEN=8, BASE_DIV=4): stimulus queues expected
// beats with their spacing, a negedge monitor checks every beat_tick against the queue.
module tb_beat_sequencer;

    localparam int LEN      = 8;
    localparam int BEAT_W   = 4;
    localparam int BASE_DIV = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              play_1p = 1'b0;
    logic              speedup_1p = 1'b0;
    logic              speeddown_1p = 1'b0;
    logic              loop_hold = 1'b0;
    logic [2:0]        loop_width = 3'd0;
    logic              ab_mark_1p = 1'b0;
    logic [BEAT_W-1:0] ibeat;
    logic              playing;
    logic [2:0]        speed;
    logic              beat_tick;
    logic [1:0]        ab_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Each entry: beat value expected at the next tick and cycles since the
    // previous tick (or since playing last rose).
    typedef struct {
        int beat;
        int gap;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    int   ref_cyc = 0;
    logic playing_prev = 1'b0;

    beat_sequencer #(
        .LEN      (LEN),
        .BEAT_W   (BEAT_W),
        .BASE_DIV (BASE_DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .play_1p      (play_1p),
        .speedup_1p   (speedup_1p),
        .speeddown_1p (speeddown_1p),
        .loop_hold    (loop_hold),
        .loop_width   (loop_width),
        .ab_mark_1p   (ab_mark_1p),
        .ibeat        (ibeat),
        .playing      (playing),
        .speed        (speed),
        .beat_tick    (beat_tick),
        .ab_state     (ab_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int beat, input int gap);
        exp_t e;
        e.beat = beat;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic wait_tick();
        int n;
        @(negedge clk);
        n = 1;
        while (beat_tick !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (beat_tick !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_timeout: no beat_tick in %0d cycles, required one", n);
        end
    endtask

    task automatic pulse_play();
        play_1p = 1'b1;
        cycle();
        play_1p = 1'b0;
    endtask

    task automatic pulse_mark();
        ab_mark_1p = 1'b1;
        cycle();
        ab_mark_1p = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ibeat"}, 32'(ibeat), 0);
        check({tag, "_playing"}, 32'(playing), 0);
        check({tag, "_speed"}, 32'(speed), 2);
        check({tag, "_beat_tick"}, 32'(beat_tick), 0);
        check({tag, "_ab_state"}, 32'(ab_state), 0);
    endtask

    // Monitor: every tick must match the head of the expectation queue.
    always @(negedge clk) begin
        if (beat_tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_tick: ibeat=%0d at cycle %0d, required no beat", ibeat, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat_value", 32'(ibeat), mon_e.beat);
                check("beat_gap", cyc - ref_cyc, mon_e.gap);
            end
            ref_cyc = cyc;
        end
        if (playing === 1'b1 && playing_prev !== 1'b1) ref_cyc = cyc;
        playing_prev = playing;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq3[11] = '{7, 0, 1, 2, 3, 6, 7, 0, 1, 2, 3};
        int seq4[8]  = '{6, 7, 0, 1, 6, 7, 0, 1};

        repeat (3) cycle();
        check_reset_state("reset");
        rst = 1'b0;

        // Linear playback at speed 2, then speed up to P=1 and saturate.
        for (int b = 1; b < LEN; b++) push(b, 4);
        push(0, 4);
        pulse_play();
        check("play_on", 32'(playing), 1);
        repeat (8) wait_tick();
        push(1, 3);
        push(2, 1);
        push(3, 1);
        speedup_1p = 1'b1;
        cycle();
        cycle();
        check("speed_max", 32'(speed), 4);
        cycle();
        speedup_1p = 1'b0;
        check("speed_sat_hi", 32'(speed), 4);
        cycle();
        cycle();
        pulse_play();
        check("pause_p1_playing", 32'(playing), 0);
        check("pause_p1_ibeat", 32'(ibeat), 3);

        // Speed 0 (P=16), long pause, resume.
        speeddown_1p = 1'b1;
        repeat (5) cycle();
        speeddown_1p = 1'b0;
        check("speed_sat_lo", 32'(speed), 0);
        repeat (50) cycle();
        check("pause_hold_ibeat", 32'(ibeat), 3);
        check("pause_hold_playing", 32'(playing), 0);
        push(4, 16);
        pulse_play();
        check("resume_playing", 32'(playing), 1);
        wait_tick();
        push(5, 6);
        push(6, 4);
        speedup_1p = 1'b1;
        cycle();
        cycle();
        speedup_1p = 1'b0;
        check("speed_back_2", 32'(speed), 2);
        wait_tick();
        wait_tick();

        // Hold-loop at 6 with width 7 clamped to 6, width change while held ignored.
        foreach (seq3[i]) push(seq3[i], 4);
        loop_hold  = 1'b1;
        loop_width = 3'd7;
        cycle();
        loop_width = 3'd2;
        repeat (11) wait_tick();
        push(4, 4);
        push(5, 4);
        push(6, 4);
        loop_hold = 1'b0;
        repeat (3) wait_tick();

        // A-B loop wrapping the song end: A=6, B=1.
        push(7, 4);
        push(0, 4);
        push(1, 4);
        pulse_mark();
        check("ab_a_set", 32'(ab_state), 1);
        repeat (3) wait_tick();
        foreach (seq4[i]) push(seq4[i], 4);
        pulse_mark();
        check("ab_active", 32'(ab_state), 2);
        repeat (8) wait_tick();
        push(2, 4);
        pulse_mark();
        check("ab_off", 32'(ab_state), 0);
        wait_tick();

        // Empty A-B loop rejected, then hold overriding an active A-B jump.
        push(3, 4);
        push(4, 4);
        push(5, 4);
        ab_mark_1p = 1'b1;
        cycle();
        check("ab_empty_a_set", 32'(ab_state), 1);
        cycle();
        ab_mark_1p = 1'b0;
        check("ab_empty_reject", 32'(ab_state), 0);
        wait_tick();
        pulse_mark();
        check("ab_a3_set", 32'(ab_state), 1);
        wait_tick();
        loop_hold  = 1'b1;
        loop_width = 3'd1;
        cycle();
        push(4, 4);
        push(5, 4);
        push(4, 4);
        wait_tick();
        pulse_mark();
        check("ab_b5_active", 32'(ab_state), 2);
        repeat (3) wait_tick();
        push(5, 4);
        push(3, 4);
        push(4, 4);
        loop_hold = 1'b0;
        repeat (3) wait_tick();
        loop_hold = 1'b1;
        cycle();
        cycle();
        rst        = 1'b1;
        play_1p    = 1'b1;
        speedup_1p = 1'b1;
        loop_hold  = 1'b0;
        cycle();
        rst        = 1'b0;
        play_1p    = 1'b0;
        speedup_1p = 1'b0;
        check_reset_state("midloop_reset");

        // Simultaneous up/down leaves cnt running; pause on cnt==P-1 wins.
        push(1, 4);
        pulse_play();
        check("replay_playing", 32'(playing), 1);
        wait_tick();
        push(2, 4);
        speedup_1p   = 1'b1;
        speeddown_1p = 1'b1;
        cycle();
        speedup_1p   = 1'b0;
        speeddown_1p = 1'b0;
        check("speed_both", 32'(speed), 2);
        wait_tick();
        repeat (3) cycle();
        pulse_play();
        check("pause_at_last_playing", 32'(playing), 0);
        check("pause_at_last_ibeat", 32'(ibeat), 2);
        repeat (10) cycle();
        check("pause_at_last_hold", 32'(ibeat), 2);
        push(3, 1);
        push(4, 4);
        pulse_play();
        check("final_resume", 32'(playing), 1);
        wait_tick();
        wait_tick();
        repeat (3) cycle();
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
